// File: rtl/cache_victim_sel_pkg.sv
// Shared definitions for the victim selector: policy encodings, FSM state
// type, LFSR seed/step and the per-set state width helper.
package cache_victim_sel_pkg;

    // Replacement policy encodings (value of the POLICY parameter)
    localparam int POL_FIFO = 0;
    localparam int POL_PLRU = 1;
    localparam int POL_LFSR = 2;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // One entry must hold either a FIFO pointer or a PLRU tree.
    function automatic int set_state_w(input int way);
        int wayw;
        wayw = $clog2(way);
        return (way - 1 > wayw) ? way - 1 : wayw;
    endfunction

    // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting toward the MSB.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/cache_victim_sel_if.sv
// Victim selector bus: request/response, hit (touch) and allocate (fill)
// notifications, flush and init status.
//   master: cache controller side (drives request/touch/fill/flush)
//   slave : cache_victim_sel
interface cache_victim_sel_if #(
    parameter int WAY  = 4,
    parameter int SETS = 256
);
    localparam int WAYW = $clog2(WAY);
    localparam int IDXW = $clog2(SETS);

    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [IDXW-1:0] req_idx;
    logic [WAY-1:0]  valid_in;
    logic            resp_valid;
    logic [WAYW-1:0] resp_way;
    logic            resp_invalid;
    logic            touch_valid;
    logic [IDXW-1:0] touch_idx;
    logic [WAYW-1:0] touch_way;
    logic            fill_valid;
    logic [IDXW-1:0] fill_idx;
    logic [WAYW-1:0] fill_way;
    logic            init_busy;

    modport master (
        output flush, req_valid, req_idx, valid_in,
               touch_valid, touch_idx, touch_way,
               fill_valid, fill_idx, fill_way,
        input  req_ready, resp_valid, resp_way, resp_invalid, init_busy
    );

    modport slave (
        input  flush, req_valid, req_idx, valid_in,
               touch_valid, touch_idx, touch_way,
               fill_valid, fill_idx, fill_way,
        output req_ready, resp_valid, resp_way, resp_invalid, init_busy
    );
endinterface

// File: rtl/cache_plru_update.sv
// Tree-PLRU path update and victim decode for one set (combinational).
// Tree is heap-ordered: node n has children 2n+1 (lower half) and 2n+2
// (upper half); a node bit of 1 steers the victim to the upper half.
//   tree_in            : current tree bits
//   touch_en/touch_way : hit, applied first
//   fill_en/fill_way   : allocation, applied on top of the touch
//   tree_out           : updated tree
//   victim             : way selected by tree_out
module cache_plru_update #(
    parameter  int WAY  = 4,
    localparam int WAYW = $clog2(WAY)
) (
    input  logic [WAY-2:0]  tree_in,
    input  logic            touch_en,
    input  logic [WAYW-1:0] touch_way,
    input  logic            fill_en,
    input  logic [WAYW-1:0] fill_way,
    output logic [WAY-2:0]  tree_out,
    output logic [WAYW-1:0] victim
);
    logic [WAY-2:0]             tree_t;
    logic [WAY-1:0][WAYW-1:0]   hit;
    logic [WAY-1:0]             is_vic;

    // Node at (level lv, position ps) lies on way w's path when the top lv
    // bits of w equal ps; it is set to point away from w's next bit.
    for (genvar lv = 0; lv < WAYW; lv++) begin : g_lvl
        for (genvar ps = 0; ps < (1 << lv); ps++) begin : g_pos
            localparam int N = (1 << lv) - 1 + ps;
            assign tree_t[N]   = (touch_en && ((touch_way >> (WAYW - lv)) == WAYW'(ps)))
                               ? ~touch_way[WAYW-1-lv] : tree_in[N];
            assign tree_out[N] = (fill_en && ((fill_way >> (WAYW - lv)) == WAYW'(ps)))
                               ? ~fill_way[WAYW-1-lv] : tree_t[N];
        end
    end

    // A way is the victim when every node on its path steers toward it.
    for (genvar w = 0; w < WAY; w++) begin : g_way
        for (genvar lv = 0; lv < WAYW; lv++) begin : g_lvl
            localparam int   N = (1 << lv) - 1 + (w >> (WAYW - lv));
            localparam logic B = 1'((w >> (WAYW - 1 - lv)) & 1);
            assign hit[w][lv] = (tree_out[N] == B);
        end
        assign is_vic[w] = &hit[w];
    end

    always_comb begin
        victim = '0;
        for (int w = 0; w < WAY; w++)
            if (is_vic[w]) victim = WAYW'(w);
    end

endmodule

// File: rtl/cache_victim_sel.sv
// Cache replacement victim selector (FIFO / tree-PLRU / LFSR-random).
// After reset or flush the per-set state is swept to zero one set per cycle
// (INIT); requests are accepted only in RUN. The response is registered and
// appears the cycle after acceptance. Invalid ways always win over policy.
//   clk, reset : clock, synchronous active-high reset
//   bus        : cache_victim_sel_if slave (request/response, touch, fill,
//                flush, init_busy)
module cache_victim_sel
    import cache_victim_sel_pkg::*;
#(
    parameter int WAY    = 4,
    parameter int SETS   = 256,
    parameter int POLICY = POL_FIFO
) (
    input  logic               clk,
    input  logic               reset,
    cache_victim_sel_if.slave  bus
);
    localparam int WAYW = $clog2(WAY);
    localparam int IDXW = $clog2(SETS);
    localparam int SW   = set_state_w(WAY);

    typedef struct packed {
        logic            vld;
        logic            inv;
        logic [WAYW-1:0] way;
    } resp_t;

    state_e          state_q, state_d;
    logic [IDXW-1:0] cnt_q, cnt_d;
    logic            run;

    logic [SETS-1:0][SW-1:0]   st_q, st_nxt;
    logic [SETS-1:0][WAYW-1:0] set_vic;
    logic                      touch_en, fill_en;

    logic [15:0]     lfsr_q;
    logic            accept, all_v;
    logic [WAYW-1:0] inv_way, pol_way;
    resp_t           resp_q;

    assign run = (state_q == ST_RUN);

    // ---------------- sweep FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;   // wraps to 0 on the last set
                if (cnt_q == IDXW'(SETS - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.flush) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // ---------------- per-set policy state ----------------
    assign touch_en = bus.touch_valid & run;
    assign fill_en  = bus.fill_valid  & run;

    // Every set computes its own next state and victim; the requested set's
    // victim is then muxed out, which gives same-cycle forwarding for free.
    for (genvar s = 0; s < SETS; s++) begin : g_set
        logic            hit_t, hit_f;
        logic [WAY-2:0]  tree_nxt;
        logic [WAYW-1:0] tree_vic, ptr_nxt;

        assign hit_t = touch_en && (bus.touch_idx == IDXW'(s));
        assign hit_f = fill_en  && (bus.fill_idx  == IDXW'(s));

        cache_plru_update #(.WAY(WAY)) u_plru (
            .tree_in   (st_q[s][WAY-2:0]),
            .touch_en  (hit_t),
            .touch_way (bus.touch_way),
            .fill_en   (hit_f),
            .fill_way  (bus.fill_way),
            .tree_out  (tree_nxt),
            .victim    (tree_vic)
        );

        assign ptr_nxt = st_q[s][WAYW-1:0] + WAYW'(hit_f);

        assign st_nxt[s]  = (POLICY == POL_PLRU) ? SW'(tree_nxt) :
                            (POLICY == POL_FIFO) ? SW'(ptr_nxt)  : st_q[s];
        assign set_vic[s] = (POLICY == POL_PLRU) ? tree_vic : ptr_nxt;
    end

    // No reset on the array: the sweep that follows reset clears it.
    always_ff @(posedge clk) begin
        if (!run) st_q[cnt_q] <= '0;
        else      st_q        <= st_nxt;
    end

    // ---------------- LFSR ----------------
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_next(lfsr_q);
    end

    // ---------------- victim select / response ----------------
    assign accept = bus.req_valid & run;
    assign all_v  = &bus.valid_in;

    always_comb begin
        inv_way = '0;
        for (int i = WAY - 1; i >= 0; i--)
            if (!bus.valid_in[i]) inv_way = WAYW'(i);
    end

    always_comb begin
        if (POLICY == POL_LFSR) pol_way = lfsr_q[WAYW-1:0];
        else                    pol_way = set_vic[bus.req_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_q <= '0;
        end else begin
            resp_q.vld <= accept;
            if (accept) begin
                resp_q.inv <= ~all_v;
                resp_q.way <= all_v ? pol_way : inv_way;
            end
        end
    end

    assign bus.req_ready    = run;
    assign bus.init_busy    = ~run;
    assign bus.resp_valid   = resp_q.vld;
    assign bus.resp_way     = resp_q.way;
    assign bus.resp_invalid = resp_q.inv;

endmodule

// File: tb/tb_cache_victim_sel.sv
// Runs FIFO, PLRU and LFSR instances side by side on identical stimulus and
// compares each against a behavioural model of the replacement rules.
module tb_cache_victim_sel;
    localparam int WAY  = 4;
    localparam int SETS = 8;

    logic       clk;
    logic       rst, flush, req_v, tv, fv;
    logic [2:0] idx, tidx, fidx;
    logic [3:0] vin;
    logic [1:0] tway, fway;

    logic [2:0]      rdy_a, busy_a, rv_a, inv_a;
    logic [2:0][1:0] way_a;

    for (genvar p = 0; p < 3; p++) begin : g_dut
        cache_victim_sel_if #(.WAY(WAY), .SETS(SETS)) bus ();
        assign bus.flush       = flush;
        assign bus.req_valid   = req_v;
        assign bus.req_idx     = idx;
        assign bus.valid_in    = vin;
        assign bus.touch_valid = tv;
        assign bus.touch_idx   = tidx;
        assign bus.touch_way   = tway;
        assign bus.fill_valid  = fv;
        assign bus.fill_idx    = fidx;
        assign bus.fill_way    = fway;
        assign rdy_a[p]  = bus.req_ready;
        assign busy_a[p] = bus.init_busy;
        assign rv_a[p]   = bus.resp_valid;
        assign inv_a[p]  = bus.resp_invalid;
        assign way_a[p]  = bus.resp_way;

        cache_victim_sel #(.WAY(WAY), .SETS(SETS), .POLICY(p)) u_dut (
            .clk(clk), .reset(rst), .bus(bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_run;
    int          m_left;
    logic [15:0] m_lfsr;
    int          fifo_m [SETS];
    bit          plru_m [SETS][WAY];
    bit          e_rv, e_inv;
    int          e_way [3];

    function automatic void clear_sets();
        for (int s = 0; s < SETS; s++) begin
            fifo_m[s] = 0;
            for (int n = 0; n < WAY; n++) plru_m[s][n] = 1'b0;
        end
    endfunction

    // Walk the halves of the way range; nodes point away from the access.
    function automatic void plru_access(input int s, input int way);
        int lo = 0, hi = WAY, node = 0, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (way < mid) begin plru_m[s][node] = 1'b1; node = 2*node + 1; hi = mid; end
            else           begin plru_m[s][node] = 1'b0; node = 2*node + 2; lo = mid; end
        end
    endfunction

    function automatic int plru_victim(input int s);
        int lo = 0, hi = WAY, node = 0, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (plru_m[s][node]) begin node = 2*node + 2; lo = mid; end
            else                 begin node = 2*node + 1; hi = mid; end
        end
        return lo;
    endfunction

    // State change produced by the coming clock edge for the current inputs.
    task automatic model_step();
        logic [15:0] lfsr_s;
        int w;
        if (rst) begin
            m_run = 0; m_left = SETS; m_lfsr = 16'hACE1; e_rv = 0;
            clear_sets();
            return;
        end
        lfsr_s = m_lfsr;
        if (m_run) begin
            if (tv) plru_access(tidx, tway);
            if (fv) begin
                plru_access(fidx, fway);
                fifo_m[fidx] = (fifo_m[fidx] + 1) % WAY;
            end
        end
        e_rv = req_v && m_run;
        if (e_rv) begin
            if (vin != 4'hF) begin
                w = 0;
                for (int i = WAY - 1; i >= 0; i--) if (!vin[i]) w = i;
                e_inv = 1;
                for (int p = 0; p < 3; p++) e_way[p] = w;
            end else begin
                e_inv = 0;
                e_way[0] = fifo_m[idx];
                e_way[1] = plru_victim(idx);
                e_way[2] = lfsr_s % WAY;
            end
        end
        if (m_run) begin
            if (flush) begin m_run = 0; m_left = SETS; clear_sets(); end
        end else begin
            m_left--;
            if (m_left == 0) m_run = 1;
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    task automatic check_outputs();
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("req_ready[%0d]", p), rdy_a[p], m_run);
            chk($sformatf("init_busy[%0d]", p), busy_a[p], !m_run);
            chk($sformatf("resp_valid[%0d]", p), rv_a[p], e_rv);
            if (e_rv) begin
                chk($sformatf("resp_way[%0d]", p), way_a[p], e_way[p]);
                chk($sformatf("resp_invalid[%0d]", p), inv_a[p], e_inv);
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clr();
        rst = 0; flush = 0; req_v = 0; idx = 0; vin = 4'hF;
        tv = 0; tidx = 0; tway = 0; fv = 0; fidx = 0; fway = 0;
    endtask

    task automatic req(input int i, input logic [3:0] v);
        req_v = 1; idx = 3'(i); vin = v;
        cycle();
        clr();
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!rdy_a[0] && n < 20) begin cycle(); n++; end
        chk(tag, n, 8);
    endtask

    initial begin
        clr();
        rst = 1;
        cycle();
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("rst_way[%0d]", p), way_a[p], 0);
            chk($sformatf("rst_inv[%0d]", p), inv_a[p], 0);
        end
        rst = 0;

        // Sweep after reset: ready rises after the 8th sweep cycle
        for (int i = 1; i <= 8; i++) begin
            cycle();
            chk($sformatf("init_ready_c%0d", i), rdy_a[0], (i == 8));
        end

        // Invalid way wins for every policy
        req(0, 4'b1011);
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("inv_way[%0d]", p), way_a[p], 2);
            chk($sformatf("inv_flag[%0d]", p), inv_a[p], 1);
        end

        // FIFO: three fills to set 3
        for (int i = 0; i < 3; i++) begin
            fv = 1; fidx = 3; fway = 2'(i);
            cycle();
            clr();
        end
        req(3, 4'hF);
        chk("fifo_three_fills", way_a[0], 3);
        chk("fifo_valid_inv", inv_a[0], 0);

        // FIFO forwarding: fill and request the same set together
        fv = 1; fidx = 2; fway = 0;
        req(2, 4'hF);
        chk("fifo_fwd", way_a[0], 1);

        // PLRU: touch 1,2,3 in set 5 -> victim 0; touch 0 -> victim 2
        for (int w = 1; w <= 3; w++) begin
            tv = 1; tidx = 5; tway = 2'(w);
            cycle();
            clr();
        end
        req(5, 4'hF);
        chk("plru_after_123", way_a[1], 0);
        tv = 1; tidx = 5; tway = 0;
        cycle();
        clr();
        req(5, 4'hF);
        chk("plru_after_0", way_a[1], 2);

        // Flush in RUN re-sweeps; every set then starts from way 0
        flush = 1;
        cycle();
        clr();
        wait_ready("flush_sweep_len");
        for (int s = 0; s < SETS; s++) begin
            req(s, 4'hF);
            chk($sformatf("flush_fifo_s%0d", s), way_a[0], 0);
            chk($sformatf("flush_plru_s%0d", s), way_a[1], 0);
        end

        // Reset in sweep cycle 4 restarts the count
        fv = 1; fidx = 6;
        cycle();
        clr();
        flush = 1;
        cycle();
        clr();
        for (int i = 0; i < 3; i++) cycle();
        rst = 1;
        cycle();
        rst = 0;
        wait_ready("reset_restart_len");

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            rst   = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 99) == 0);
            req_v = 1'($urandom_range(0, 1));
            idx   = 3'($urandom_range(0, 7));
            vin   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            tv    = ($urandom_range(0, 2) == 0);
            tidx  = 3'($urandom_range(0, 7));
            tway  = 2'($urandom);
            fv    = ($urandom_range(0, 2) == 0);
            fidx  = ($urandom_range(0, 1) == 0) ? tidx : 3'($urandom_range(0, 7));
            fway  = 2'($urandom);
            cycle();
        end
        clr();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cache_victim_sel.md
CACHE_VICTIM_SEL -- requirements
Module: cache_victim_sel

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- WAY, 4, associativity; power of two, 2..8.
- SETS, 256, number of sets; power of two.
- POLICY, 0, replacement policy: 0 FIFO, 1 tree-PLRU, 2 LFSR-random.
REQ-002 Derived widths: WAYW=$clog2(WAY); IDXW=$clog2(SETS).
REQ-003 Ports SHALL be, one per line (name direction width meaning):
- clk in 1: clock.
- reset in 1: reset, synchronous, active-high.
- flush in 1: pulse; clears all replacement state.
- req_valid in 1: victim request.
- req_ready out 1: request accepted when req_valid&&req_ready.
- req_idx in IDXW: set of the request.
- valid_in in WAY: V bits of the requested set, sampled at acceptance.
- resp_valid out 1: one-cycle pulse carrying the victim.
- resp_way out WAYW: victim way.
- resp_invalid out 1: victim was an invalid way.
- touch_valid/touch_idx/touch_way in 1/IDXW/WAYW: hit notification.
- fill_valid/fill_idx/fill_way in 1/IDXW/WAYW: line allocated into a way.
- init_busy out 1: state sweep in progress.

Function
REQ-010 The FSM SHALL have two states: INIT and RUN.
REQ-011 In INIT, a counter SHALL clear per-set state one set per cycle, from index 0 to SETS-1, then go to RUN; INIT lasts exactly SETS cycles.
REQ-012 In RUN, flush SHALL enter INIT with the counter at 0; flush during INIT SHALL be ignored.
REQ-013 req_ready and ~init_busy SHALL both equal (state==RUN); touch and fill SHALL be ignored in INIT.
REQ-014 resp_valid SHALL pulse exactly one cycle after acceptance; back-to-back requests SHALL give back-to-back responses.
REQ-015 If valid_in is not all ones, resp_way SHALL be the lowest-index zero bit and resp_invalid=1, for every policy.
REQ-016 Otherwise resp_invalid=0 and resp_way SHALL come from the policy state of req_idx.
REQ-017 Policy state of a set accepted in the same cycle as a touch/fill to that set SHALL reflect the update (forwarded).
REQ-018 FIFO: a WAYW-bit pointer per set; the victim is the pointer; +1 mod WAY on fill; touch has no effect.
REQ-019 Tree-PLRU: WAY-1 bits per set, heap-ordered.
- Node bit 0 SHALL steer the victim to the lower half; 1 to the upper half.
- Touch or fill SHALL set every node on the accessed way's path to point away from it.
- Touch and fill to the same set in one cycle: touch applied first, then fill.
REQ-020 LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1.
- Advances every cycle, including INIT.
- Victim = lfsr[WAYW-1:0] sampled at acceptance; no per-set state.
REQ-021 A request does not modify policy state; only touch/fill do.

Reset
REQ-030 Reset SHALL force: state=INIT, counter=0, req_ready=0, init_busy=1, resp_valid=0, resp_way=0, resp_invalid=0, LFSR=16'hACE1.
REQ-031 Reset mid-sweep or mid-request SHALL restart the sweep from 0 and drop any pending response.

Structure
REQ-040 Policy encodings (FIFO/PLRU/LFSR constants) SHALL reside in the shared cache.vh package; WAY and index-width definitions SHALL be shared with the existing cache tools.
REQ-041 PLRU path update and victim decode SHALL be one combinational sub-module, cache_plru_update.
REQ-042 Per-set state SHALL be a register array sized SETS x max(WAYW, WAY-1).

Verification (WAY=4, SETS=8)
REQ-050 Release reset -> req_ready=0 for 8 cycles, =1 in cycle 8; init_busy mirrors it.
REQ-051 FIFO, three fills to set 3, then req set 3, valid_in=4'b1111 -> resp_way=3, resp_invalid=0, one cycle later.
REQ-052 Any policy, req with valid_in=4'b1011 -> resp_way=2, resp_invalid=1.
REQ-053 PLRU, touch ways 1,2,3 in set 5, then req valid_in=4'b1111 -> resp_way=0; after touching 0 -> resp_way=2.
REQ-054 FIFO, pointer of set 2 =0; fill set 2 and req set 2 in the same cycle -> resp_way=1 (forwarded).
REQ-055 FIFO after fills, flush in RUN -> req_ready=0 for 8 cycles; then every set's req -> resp_way=0; reset asserted in cycle 4 of the sweep restarts the 8-cycle count.
